// File: rtl/i2c_reg_ctrl_if.sv
// PHY and register-bank signals of i2c_reg_ctrl.
// slave: the controller. master: the PHY and bank side.
interface i2c_reg_ctrl_if #(
    parameter int unsigned REG_AW = 8
);
    logic              phy_start;
    logic              phy_stop;
    logic              phy_rx_valid;
    logic [7:0]        phy_rx_data;
    logic              phy_ack;
    logic              phy_tx_valid;
    logic [7:0]        phy_tx_data;
    logic              phy_tx_ready;
    logic              phy_host_nack;
    logic [REG_AW-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic              busy;
    logic [2:0]        state_dbg;

    modport slave (
        input  phy_start, phy_stop, phy_rx_valid, phy_rx_data,
        input  phy_tx_ready, phy_host_nack, reg_rdata,
        output phy_ack, phy_tx_valid, phy_tx_data,
        output reg_addr, reg_wdata, reg_we, reg_re, busy, state_dbg
    );

    modport master (
        output phy_start, phy_stop, phy_rx_valid, phy_rx_data,
        output phy_tx_ready, phy_host_nack, reg_rdata,
        input  phy_ack, phy_tx_valid, phy_tx_data,
        input  reg_addr, reg_wdata, reg_we, reg_re, busy, state_dbg
    );
endinterface

// File: rtl/i2c_reg_ctrl.sv
// I2C target transaction controller: address decode, register pointer,
// register writes and prefetched reads with pointer auto-increment.
// Build option: I2C_REG_CTRL_PTR_WRAP_EN makes the pointer wrap to 0;
// otherwise it saturates at the top register and further writes are NACKed.
module i2c_reg_ctrl #(
    parameter logic [6:0]  I2C_ADDR = 7'h42,
    parameter int unsigned REG_AW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    i2c_reg_ctrl_if.slave bus
);

`ifdef I2C_REG_CTRL_PTR_WRAP_EN
    localparam bit PTR_WRAP = 1'b1;
`else
    localparam bit PTR_WRAP = 1'b0;
`endif

    localparam logic [REG_AW-1:0] PTR_MAX = {REG_AW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_PTR    = 3'd2,
        S_WRITE  = 3'd3,
        S_FETCH  = 3'd4,
        S_WAITRD = 3'd5,
        S_SEND   = 3'd6,
        S_SKIP   = 3'd7
    } state_e;

    state_e            state_q, state_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic [REG_AW-1:0] ptr_inc;
    logic              full_q, full_d;
    logic              ack_q, ack_d;
    logic              txv_q, txv_d;
    logic [7:0]        txd_q, txd_d;
    logic [REG_AW-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              busy_q, busy_d;
    logic [2:0]        dbg_q, dbg_d;

    // Pointer increment, wrapping or saturating at the top register
    always_comb begin
        if (!PTR_WRAP && (ptr_q == PTR_MAX)) begin
            ptr_inc = ptr_q;
        end else begin
            ptr_inc = ptr_q + REG_AW'(1);
        end
    end

    // Next-state and output decode; stop > start > host NACK > byte/handshake
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        full_d  = full_q;
        ack_d   = ack_q;
        txv_d   = txv_q;
        txd_d   = txd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        re_d    = 1'b0;

        // the pointer steps in the cycle after a write strobe
        if (we_q) begin
            ptr_d = ptr_inc;
        end

        if (bus.phy_stop) begin
            state_d = S_IDLE;
            ack_d   = 1'b0;
            txv_d   = 1'b0;
        end else if (bus.phy_start) begin
            state_d = S_ADDR;
            ack_d   = 1'b0;
            txv_d   = 1'b0;
        end else if (bus.phy_host_nack &&
                     (state_q == S_SEND || state_q == S_FETCH || state_q == S_WAITRD)) begin
            state_d = S_SKIP;
            txv_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.phy_rx_valid) ack_d = 1'b0;
                end
                S_ADDR: begin
                    if (bus.phy_rx_valid) begin
                        if (bus.phy_rx_data[7:1] == I2C_ADDR) begin
                            ack_d = 1'b1;
                            if (bus.phy_rx_data[0]) begin
                                // read: issue the first fetch on entry to FETCH
                                state_d = S_FETCH;
                                re_d    = 1'b1;
                                addr_d  = ptr_q;
                            end else begin
                                state_d = S_PTR;
                            end
                        end else begin
                            ack_d   = 1'b0;
                            state_d = S_SKIP;
                        end
                    end
                end
                S_PTR: begin
                    if (bus.phy_rx_valid) begin
                        ptr_d   = REG_AW'(bus.phy_rx_data);
                        full_d  = 1'b0;
                        ack_d   = 1'b1;
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus.phy_rx_valid) begin
                        if (!PTR_WRAP && full_q) begin
                            ack_d = 1'b0;
                        end else begin
                            we_d    = 1'b1;
                            addr_d  = ptr_q;
                            wdata_d = bus.phy_rx_data;
                            ack_d   = 1'b1;
                            full_d  = !PTR_WRAP && (ptr_q == PTR_MAX);
                        end
                    end
                end
                S_FETCH: begin
                    if (bus.phy_rx_valid) ack_d = 1'b0;
                    state_d = S_WAITRD;
                end
                S_WAITRD: begin
                    if (bus.phy_rx_valid) ack_d = 1'b0;
                    txd_d   = bus.reg_rdata;
                    txv_d   = 1'b1;
                    state_d = S_SEND;
                end
                S_SEND: begin
                    if (bus.phy_rx_valid) ack_d = 1'b0;
                    if (txv_q && bus.phy_tx_ready) begin
                        // prefetch the next register straight away
                        txv_d   = 1'b0;
                        ptr_d   = ptr_inc;
                        addr_d  = ptr_inc;
                        re_d    = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_SKIP: begin
                    if (bus.phy_rx_valid) ack_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
        dbg_d  = 3'(state_d);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            full_q  <= 1'b0;
            ack_q   <= 1'b0;
            txv_q   <= 1'b0;
            txd_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            busy_q  <= 1'b0;
            dbg_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            full_q  <= full_d;
            ack_q   <= ack_d;
            txv_q   <= txv_d;
            txd_q   <= txd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            busy_q  <= busy_d;
            dbg_q   <= dbg_d;
        end
    end

    assign bus.phy_ack      = ack_q;
    assign bus.phy_tx_valid = txv_q;
    assign bus.phy_tx_data  = txd_q;
    assign bus.reg_addr     = addr_q;
    assign bus.reg_wdata    = wdata_q;
    assign bus.reg_we       = we_q;
    assign bus.reg_re       = re_q;
    assign bus.busy         = busy_q;
    assign bus.state_dbg    = dbg_q;

endmodule

// File: doc/i2c_reg_ctrl.md
# i2c_reg_ctrl

Transaction-layer controller between the byte-level I2C target PHY and the fabric register bank. It decodes the target address byte, loads a register pointer, and sequences register writes and prefetched register reads with pointer auto-increment. It sits inside `main`, between the SDA/SCL PHY and the register file, and exports status for the debug port.

## Interface

- `I2C_ADDR`, 7'h42: 7-bit target address matched against the address byte.
- `REG_AW`, 8: register pointer width; the bank holds 2^REG_AW bytes.
- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous, active-high.
- `phy_start` in 1: one-cycle pulse on START or repeated START.
- `phy_stop` in 1: one-cycle pulse on STOP.
- `phy_rx_valid` in 1: one-cycle pulse; a received byte is on `phy_rx_data`.
- `phy_rx_data` in 8: received byte.
- `phy_ack` out 1: ACK decision for the last received byte, held until the next `phy_rx_valid`, `phy_start` or `phy_stop`.
- `phy_tx_valid` out 1: read byte available.
- `phy_tx_data` out 8: read byte.
- `phy_tx_ready` in 1: PHY consumes the byte when valid and ready are both high.
- `phy_host_nack` in 1: one-cycle pulse; the host NACKed the last read byte.
- `reg_addr` out REG_AW: register address.
- `reg_wdata` out 8: write data.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read strobe.
- `reg_rdata` in 8: read data, valid exactly 1 cycle after `reg_re`.
- `busy` out 1: high when state is not IDLE.
- `state_dbg` out 3: current state encoding, for the debug port.

## Operation

States and their encodings:
- IDLE=0, ADDR=1, PTR=2, WRITE=3, FETCH=4, WAITRD=5, SEND=6, SKIP=7.

Transitions:
- IDLE: `phy_start` moves to ADDR.
- ADDR: on `phy_rx_valid`, compare `phy_rx_data[7:1]` with I2C_ADDR.
  - Match with bit0=0: ACK, go to PTR.
  - Match with bit0=1: ACK, go to FETCH.
  - Mismatch: `phy_ack`=0, go to SKIP.
- PTR: on a byte, ptr←byte (truncated to REG_AW bits), ACK, go to WRITE.
- WRITE: on each byte, drive `reg_we`=1 for one cycle with `reg_addr`=ptr and `reg_wdata`=byte, ACK, then ptr←ptr+1 (see Configuration).
- FETCH: drive `reg_re`=1 for one cycle at ptr, go to WAITRD.
- WAITRD: latch `reg_rdata` into `phy_tx_data`, set `phy_tx_valid`, go to SEND.
- SEND: on a valid∧ready handshake, drop `phy_tx_valid`, ptr←ptr+1, go to FETCH (prefetch of the next byte).
- `phy_host_nack` in SEND, FETCH or WAITRD: drop `phy_tx_valid`, go to SKIP. No further `reg_re` is issued.
- SKIP: ignore all bytes, `phy_ack`=0.

Global rules and priority:
- `phy_stop` in any state: go to IDLE, clear `phy_tx_valid` and `phy_ack`. The pointer is retained.
- `phy_start` in any non-IDLE state: go to ADDR (repeated START). The pointer is retained, so a write-pointer-then-restart-read sequence works.
- Priority, highest first: `rst` > `phy_stop` > `phy_start` > `phy_host_nack` > `phy_rx_valid`/handshake. A lower-priority event in the same cycle is dropped.
- `phy_rx_valid` in FETCH, WAITRD or SEND is ignored and `phy_ack`=0.
- `reg_we` and `reg_re` are never high in the same cycle.

## Timing

- All outputs are registered.
- Reset values: state IDLE, ptr 0, and `phy_ack`, `phy_tx_valid`, `phy_tx_data`, `reg_addr`, `reg_wdata`, `reg_we`, `reg_re`, `busy`, `state_dbg` all 0.
- `phy_ack` is valid 1 cycle after `phy_rx_valid`. The PHY samples it no earlier than 2 cycles after delivering the byte.
- `reg_we` is asserted 1 cycle after `phy_rx_valid`.
- Read latency: `reg_re` is high in cycle t, `phy_tx_valid` rises in cycle t+2.
- After a handshake at cycle h: the next `reg_re` is at h+1 and the next `phy_tx_valid` is at h+3.
- `phy_tx_data` stays stable while `phy_tx_valid`=1 and ready=0.
- ptr increments in the cycle after a write strobe or a handshake.

## Configuration

- `I2C_REG_CTRL_PTR_WRAP_EN` defined: ptr wraps from 2^REG_AW−1 to 0 on increment.
- Not defined: ptr saturates at 2^REG_AW−1.
  - A write byte arriving after a saturated write is NACKed (`phy_ack`=0) and no `reg_we` is issued.
  - Reads keep returning the last register.

## Test plan

- Write, default parameters: START, 0x84, 0x10, 0xAA, 0x55, STOP → four ACKs; `reg_we` at addr 0x10 data 0xAA, then addr 0x11 data 0x55; `busy` back to 0 one cycle after STOP.
- Combined read with bank preset 0x10=0x3C, 0x11=0x7E: START, 0x84, 0x10, repeated START, 0x85, two handshakes, `phy_host_nack` → tx bytes 0x3C then 0x7E; one further `reg_re` at 0x12 (prefetch); state SKIP until STOP.
- Address mismatch: START, 0x86, 0x01, STOP → `phy_ack`=0 throughout; no `reg_we`/`reg_re`; state_dbg=7 then 0.
- Pointer boundary at ptr=0xFF, writing 0x11 then 0x22:
  - With the wrap macro: writes land at 0xFF then 0x00.
  - Without it: 0xFF is written and the second byte is NACKed.
- Simultaneous events: `phy_stop` and `phy_start` together in WRITE → IDLE, not ADDR. `rst` asserted in SEND with `phy_tx_valid`=1 → all outputs 0 on the next cycle and ptr=0.
